// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - accumulates a burst of multiplier products and presents the total over valid/ready
module product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [PROD_W-1:0] i_in_prod,
  input  logic              i_in_last,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_out_sum,
  output logic [7:0]        o_out_count,
  output logic              o_out_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [ACC_W-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic             r_ovf;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic [7:0]       r_out_count;
  logic             r_out_ovf;

  logic [ACC_W:0]   w_sum_nx;
  logic             w_beat;
  logic             w_final;

  // Extra top bit of the sum is the carry out that feeds the sticky overflow.
  assign w_sum_nx = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_in_prod};
  assign w_beat   = i_in_valid && (r_state == ACCUM);
  assign w_final  = w_beat && (i_in_last || (r_cnt == 8'(LEN - 1)));

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ACCUM: if (w_final) w_state_nx = HOLD;
      HOLD:  if (i_out_ready) w_state_nx = ACCUM;
      default: w_state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_final) begin
        r_out_sum   <= w_sum_nx[ACC_W-1:0];
        r_out_count <= r_cnt + 8'd1;
        r_out_ovf   <= r_ovf | w_sum_nx[ACC_W];
        r_out_valid <= 1'b1;
        r_acc       <= '0;
        r_cnt       <= '0;
        r_ovf       <= 1'b0;
      end else if (w_beat) begin
        r_acc <= w_sum_nx[ACC_W-1:0];
        r_cnt <= r_cnt + 8'd1;
        r_ovf <= r_ovf | w_sum_nx[ACC_W];
      end
      if ((r_state == HOLD) && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Ready depends only on registered state so there is no path from the output side.
  assign o_in_ready  = (r_state == ACCUM);
  assign o_out_valid = r_out_valid;
  assign o_out_sum   = r_out_sum;
  assign o_out_count = r_out_count;
  assign o_out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed bench for product_accumulator with three parameterisations
module tb_product_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_prod;
  logic       in_last;
  logic       out_ready;
  logic [1:0] sel;

  logic        rdy0, vld0, ovf0;
  logic [15:0] sum0;
  logic [7:0]  cnt0;
  logic        rdy1, vld1, ovf1;
  logic [8:0]  sum1;
  logic [7:0]  cnt1;
  logic        rdy2, vld2, ovf2;
  logic [15:0] sum2;
  logic [7:0]  cnt2;

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(4)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid && (sel == 2'd0)), .o_in_ready(rdy0),
    .i_in_prod(in_prod), .i_in_last(in_last), .o_out_valid(vld0), .i_out_ready(out_ready),
    .o_out_sum(sum0), .o_out_count(cnt0), .o_out_ovf(ovf0));

  product_accumulator #(.PROD_W(8), .ACC_W(9), .LEN(4)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid && (sel == 2'd1)), .o_in_ready(rdy1),
    .i_in_prod(in_prod), .i_in_last(in_last), .o_out_valid(vld1), .i_out_ready(out_ready),
    .o_out_sum(sum1), .o_out_count(cnt1), .o_out_ovf(ovf1));

  product_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(1)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid && (sel == 2'd2)), .o_in_ready(rdy2),
    .i_in_prod(in_prod), .i_in_last(in_last), .o_out_valid(vld2), .i_out_ready(out_ready),
    .o_out_sum(sum2), .o_out_count(cnt2), .o_out_ovf(ovf2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] p, input logic l);
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    tick();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0; sel = 2'd0;
    tick();
    tick();
    chk("rst_valid", 32'(vld0), 0);
    chk("rst_sum",   32'(sum0), 0);
    chk("rst_count", 32'(cnt0), 0);
    chk("rst_ovf",   32'(ovf0), 0);
    chk("rst_ready", 32'(rdy0), 1);
    rst_n = 1'b1;

    send(225, 0); send(225, 0); send(225, 0);
    chk("t1_not_yet", 32'(vld0), 0);
    send(225, 0);
    chk("t1_valid", 32'(vld0), 1);
    chk("t1_sum",   32'(sum0), 900);
    chk("t1_count", 32'(cnt0), 4);
    chk("t1_ovf",   32'(ovf0), 0);

    in_valid = 1'b1; in_prod = 99; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_ready_low", 32'(rdy0), 0);
      chk("t4_valid_held", 32'(vld0), 1);
      chk("t4_sum_held", 32'(sum0), 900);
      chk("t4_count_held", 32'(cnt0), 4);
    end
    drain();
    chk("t4_valid_drop", 32'(vld0), 0);
    chk("t4_ready_back", 32'(rdy0), 1);

    send(10, 0); send(20, 1); in_valid = 1'b0;
    chk("t2a_valid", 32'(vld0), 1);
    chk("t2a_sum",   32'(sum0), 30);
    chk("t2a_count", 32'(cnt0), 2);
    drain();
    send(1, 0); send(2, 0); send(3, 0); send(4, 1); in_valid = 1'b0;
    chk("t2b_valid", 32'(vld0), 1);
    chk("t2b_sum",   32'(sum0), 10);
    chk("t2b_count", 32'(cnt0), 4);
    drain();
    tick();
    chk("t2b_no_extra", 32'(vld0), 0);

    send(5, 0); send(5, 0); in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_sum",   32'(sum0), 0);
    chk("t5_rst_count", 32'(cnt0), 0);
    chk("t5_rst_valid", 32'(vld0), 0);
    chk("t5_rst_ready", 32'(rdy0), 1);
    tick();
    rst_n = 1'b1;
    send(5, 0); send(5, 0); send(5, 0); send(5, 0); in_valid = 1'b0;
    chk("t5_sum",   32'(sum0), 20);
    chk("t5_count", 32'(cnt0), 4);
    drain();

    sel = 2'd1;
    send(225, 0); send(225, 0); send(225, 0); send(225, 0); in_valid = 1'b0;
    chk("t3a_valid", 32'(vld1), 1);
    chk("t3a_sum",   32'(sum1), 388);
    chk("t3a_ovf",   32'(ovf1), 1);
    chk("t3a_count", 32'(cnt1), 4);
    drain();
    send(1, 0); send(1, 0); send(1, 0); send(1, 0); in_valid = 1'b0;
    chk("t3b_sum", 32'(sum1), 4);
    chk("t3b_ovf", 32'(ovf1), 0);
    drain();

    sel = 2'd2;
    out_ready = 1'b1;
    send(7, 0);
    chk("t6a_valid", 32'(vld2), 1);
    chk("t6a_sum",   32'(sum2), 7);
    chk("t6a_count", 32'(cnt2), 1);
    chk("t6a_ready", 32'(rdy2), 0);
    send(9, 0);
    chk("t6_bubble_valid", 32'(vld2), 0);
    chk("t6_bubble_ready", 32'(rdy2), 1);
    tick();
    in_valid = 1'b0;
    chk("t6b_valid", 32'(vld2), 1);
    chk("t6b_sum",   32'(sum2), 9);
    chk("t6b_count", 32'(cnt2), 1);
    tick();
    chk("t6b_drop", 32'(vld2), 0);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
